// File: rtl/usb_rx_pkt_ctrl.sv
// Packet-level controller for the USB receive path: drains the rx FIFO to a
// valid/ready consumer, counts payload bytes and reports one end-of-packet status.
module usb_rx_pkt_ctrl #(
   parameter int unsigned MAX_BYTES = 64,
   parameter int unsigned CW        = $clog2(MAX_BYTES + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          rcving,
   input  logic          r_error,
   input  logic          empty,
   input  logic          full,
   input  logic [7:0]    r_data,
   input  logic [3:0]    PID,
   output logic          r_enable,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          pkt_done,
   output logic          pkt_error,
   output logic [3:0]    pkt_pid,
   output logic [CW-1:0] byte_count,
   output logic          busy
);

   localparam logic [CW-1:0] MaxCnt = CW'(MAX_BYTES);

   typedef enum logic [2:0] {StIdle, StRecv, StFlush, StDone, StErrDone} state_e;

   state_e        r_state,      w_state_d;
   logic [7:0]    r_out_data,   w_out_data_d;
   logic          r_out_valid,  w_out_valid_d;
   logic [CW-1:0] r_byte_count, w_byte_count_d;
   logic          r_err_flag,   w_err_flag_d;
   logic [3:0]    r_pkt_pid,    w_pkt_pid_d;
   logic          w_slot_free;
   logic          w_r_enable;
   logic          w_recv_err;
   logic          w_len_err;

   assign w_slot_free = !r_out_valid | out_ready;
   assign w_recv_err  = r_error | (full & rcving) | (!empty & (r_byte_count == MaxCnt));

   always_comb begin
      w_state_d      = r_state;
      w_out_data_d   = r_out_data;
      w_out_valid_d  = r_out_valid;
      w_byte_count_d = r_byte_count;
      w_err_flag_d   = r_err_flag;
      w_pkt_pid_d    = r_pkt_pid;
      w_r_enable     = 1'b0;
      case (r_state)
         StIdle: begin
            if (rcving) begin
               w_state_d      = StRecv;
               w_byte_count_d = '0;
               w_err_flag_d   = 1'b0;
            end
         end
         StRecv: begin
            w_r_enable = !empty & w_slot_free & (r_byte_count < MaxCnt);
            if (w_recv_err) begin
               // Any byte popped this cycle or still held is dropped with the packet.
               w_state_d     = StFlush;
               w_err_flag_d  = 1'b1;
               w_out_valid_d = 1'b0;
            end else begin
               if (w_r_enable) begin
                  w_out_data_d   = r_data;
                  w_out_valid_d  = 1'b1;
                  w_byte_count_d = r_byte_count + CW'(1);
               end else if (out_ready) begin
                  w_out_valid_d = 1'b0;
               end
               if (!rcving & empty & w_slot_free) begin
                  w_state_d   = StDone;
                  w_pkt_pid_d = PID;
               end
            end
         end
         StFlush: begin
            w_r_enable = !empty;
            if (!rcving & empty) begin
               w_state_d   = StErrDone;
               w_pkt_pid_d = PID;
            end
         end
         StDone:    w_state_d = StIdle;
         StErrDone: w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= StIdle;
         r_out_data   <= 8'h00;
         r_out_valid  <= 1'b0;
         r_byte_count <= '0;
         r_err_flag   <= 1'b0;
         r_pkt_pid    <= 4'h0;
      end else begin
         r_state      <= w_state_d;
         r_out_data   <= w_out_data_d;
         r_out_valid  <= w_out_valid_d;
         r_byte_count <= w_byte_count_d;
         r_err_flag   <= w_err_flag_d;
         r_pkt_pid    <= w_pkt_pid_d;
      end
   end

   // Handshake PIDs carry no payload; data PIDs need at least the CRC16.
   assign w_len_err = ((r_pkt_pid[1:0] == 2'b10) & (r_byte_count != '0)) |
                      ((r_pkt_pid[1:0] == 2'b11) & (r_byte_count < CW'(2)));

   assign r_enable   = w_r_enable;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign pkt_done   = (r_state == StDone) | (r_state == StErrDone);
   assign pkt_error  = (r_state == StErrDone) | ((r_state == StDone) & (r_err_flag | w_len_err));
   assign pkt_pid    = r_pkt_pid;
   assign byte_count = r_byte_count;
   assign busy       = (r_state != StIdle);

endmodule
